// File: rtl/seq_booth_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states and default width.
package seq_booth_multiplier_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int mul_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand,
// then arithmetic right shift of the combined {Acc, Q, Q_1} register.
module mul_booth_step #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH:0]   acc_i,
    input  logic        [WIDTH-1:0] q_i,
    input  logic                    q1_i,
    input  logic signed [WIDTH:0]   m_i,
    output logic signed [WIDTH:0]   acc_o,
    output logic        [WIDTH-1:0] q_o,
    output logic                    q1_o
);

    logic signed [WIDTH:0] sum;

    // Recode {Q[0],Q_1} into +M / -M / 0, then shift right keeping the sign of Acc.
    always_comb begin
        sum = acc_i;
        case ({q_i[0], q1_i})
            2'b01:   sum = acc_i + m_i;
            2'b10:   sum = acc_i - m_i;
            default: sum = acc_i;
        endcase
        {acc_o, q_o, q1_o} = {sum[WIDTH], sum, q_i};
    end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier: WIDTH iterations per product,
// back-to-back restart from DONE, results held until the next completion.
module seq_booth_multiplier
    import seq_booth_multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResultLo,
    output logic [WIDTH-1:0] oResultHi
);

    localparam int CNT_W = mul_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e              state_q, state_d;
    logic signed [WIDTH:0]   acc_q, acc_d;
    logic signed [WIDTH:0]   m_q, m_d;
    logic        [WIDTH-1:0] q_q, q_d;
    logic                    q1_q, q1_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [WIDTH-1:0] lo_q, lo_d;
    logic        [WIDTH-1:0] hi_q, hi_d;

    logic signed [WIDTH:0]   acc_s;
    logic        [WIDTH-1:0] q_s;
    logic                    q1_s;

    mul_booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .q_i   (q_q),
        .q1_i  (q1_q),
        .m_i   (m_q),
        .acc_o (acc_s),
        .q_o   (q_s),
        .q1_o  (q1_s)
    );

    // Next-state logic: operand load on an accepted start, one Booth step per RUN cycle,
    // result capture on the final step.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (iStart) begin
                    state_d = MUL_RUN;
                    m_d     = {iA[WIDTH-1], iA};
                    acc_d   = '0;
                    q_d     = iB;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                acc_d = acc_s;
                q_d   = q_s;
                q1_d  = q1_s;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = MUL_DONE;
                    lo_d    = q_s;
                    hi_d    = acc_s[WIDTH-1:0];
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, including an operation in flight.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= MUL_IDLE;
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign oBusy     = (state_q == MUL_RUN);
    assign oDone     = (state_q == MUL_DONE);
    assign oResultLo = lo_q;
    assign oResultHi = hi_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier with a per-cycle arithmetic reference model.
module tb_seq_booth_multiplier;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         iStart = 1'b0;
    logic [W-1:0] iA = '0;
    logic [W-1:0] iB = '0;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oResultLo;
    logic [W-1:0] oResultHi;

    seq_booth_multiplier #(
        .WIDTH (W)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iA        (iA),
        .iB        (iB),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oResultLo (oResultLo),
        .oResultHi (oResultHi)
    );

    always #5 Clock = ~Clock;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Reference model: each accepted start is recorded with the edge it was accepted on
    // and the exact signed product. The operation is busy for W cycles after that edge
    // and its product is presented in the following cycle.
    int           st_edge [64];
    logic [2*W-1:0] st_prod [64];
    int           n_st = 0;
    int           head = 0;
    logic [2*W-1:0] last_prod = '0;
    bit           en = 1'b0;
    int           total = 0;
    int           bad = 0;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_start(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        s = cyc + 1;
        st_edge[n_st] = s;
        st_prod[n_st] = model(a, b);
        n_st++;
    endtask

    task automatic cmp();
        logic exp_busy;
        logic exp_done;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (!Reset) begin
            head      = n_st;
            last_prod = '0;
        end
        if (head < n_st) begin
            if (cyc == st_edge[head] + W) begin
                exp_done  = 1'b1;
                last_prod = st_prod[head];
                head++;
            end else if (cyc >= st_edge[head]) begin
                exp_busy = 1'b1;
            end
        end
        check("busy", oBusy, exp_busy);
        check("done", oDone, exp_done);
        check("result", {oResultHi, oResultLo}, last_prod);
    endtask

    // Advance one cycle: compare at the falling edge, then leave time to drive inputs.
    task automatic tick();
        @(negedge Clock);
        if (en) cmp();
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, output int s);
        iA = a;
        iB = b;
        iStart = 1'b1;
        note_start(a, b, s);
        tick();
        iStart = 1'b0;
    endtask

    task automatic wait_done(input string name, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (oDone === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL %s: no oDone within 40 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int s2;
        int d;
        int d2;
        int n;

        // 1) reset held for two edges, then released
        repeat (2) @(posedge Clock);
        tick();
        Reset = 1'b1;
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);
        check("rst_lo", oResultLo, 16'h0000);
        check("rst_hi", oResultHi, 16'h0000);
        en = 1'b1;
        tick();

        // 2) 7 * -3 = -21, done in the 17th cycle counted from the start edge
        start_op(16'd7, 16'hFFFD, s);
        wait_done("t2", d);
        check("t2_latency", d + 1 - s, 17);
        check("t2_hi", oResultHi, 16'hFFFF);
        check("t2_lo", oResultLo, 16'hFFEB);
        tick();

        // 3) extreme operands
        start_op(16'h8000, 16'h8000, s);
        wait_done("t3a", d);
        check("t3a_hi", oResultHi, 16'h4000);
        check("t3a_lo", oResultLo, 16'h0000);
        tick();
        start_op(16'h7FFF, 16'h8000, s);
        wait_done("t3b", d);
        check("t3b_hi", oResultHi, 16'hC000);
        check("t3b_lo", oResultLo, 16'h8000);
        tick();

        // 4) 1234 * 567 = 699678 = 0x000AAD1E; a start pulse in RUN cycle 5 is ignored
        start_op(16'd1234, 16'd567, s);
        repeat (4) tick();
        iA = 16'd999;
        iB = 16'd111;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        wait_done("t4", d);
        check("t4_latency", d + 1 - s, 17);
        check("t4_hi", oResultHi, 16'h000A);
        check("t4_lo", oResultLo, 16'hAD1E);
        n = 0;
        repeat (20) begin
            tick();
            if (oDone === 1'b1) n++;
        end
        check("t4_extra_done", n, 0);

        // 5) iStart held high: 3*4, then 5*(-6) presented during the DONE cycle
        iA = 16'd3;
        iB = 16'd4;
        iStart = 1'b1;
        note_start(16'd3, 16'd4, s);
        wait_done("t5a", d);
        check("t5a_hi", oResultHi, 16'h0000);
        check("t5a_lo", oResultLo, 16'h000C);
        iA = 16'd5;
        iB = 16'hFFFA;
        note_start(16'd5, 16'hFFFA, s2);
        check("t5_restart_edge", s2 - s, 17);
        wait_done("t5b", d2);
        iStart = 1'b0;
        check("t5_done_spacing", d2 - d, 17);
        check("t5b_hi", oResultHi, 16'hFFFF);
        check("t5b_lo", oResultLo, 16'hFFE2);
        tick();
        tick();

        // 6) reset in RUN cycle 8 aborts the operation; a fresh 2*2 then completes normally
        start_op(16'd100, 16'hFF38, s);
        repeat (7) tick();
        Reset = 1'b0;
        tick();
        check("t6_busy", oBusy, 1'b0);
        check("t6_done", oDone, 1'b0);
        check("t6_lo", oResultLo, 16'h0000);
        check("t6_hi", oResultHi, 16'h0000);
        Reset = 1'b1;
        tick();
        start_op(16'd2, 16'd2, s);
        wait_done("t6b", d);
        check("t6b_latency", d + 1 - s, 17);
        check("t6b_hi", oResultHi, 16'h0000);
        check("t6b_lo", oResultLo, 16'h0004);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
